captura_jogada: RTL and testbench
=================================

// Module: captura_jogada
// PURPOSE
//   Player-input front end that produces the play handshake for the game control unit.
//   - Synchronises and debounces the answer buttons.
//   - Emits a one-cycle jogada_feita pulse per press.
//   - Stores the encoded answer index under the registraR/zeraR commands.
//   - Runs the answer timer driven by the zeraI/contaI commands.
// PARAMETERS
//   N_BOTOES        4     number of answer buttons (2..16)
//   W_JOGADA        2     width of encoded index; must satisfy 2**W_JOGADA >= N_BOTOES
//   DEBOUNCE_CICLOS 1000  consecutive stable cycles required to accept a button level (>=1)
//   TIMEOUT_CICLOS  5000  timer cycles until timeout asserts (>=1)
// PORTS
//   clock         in   1         system clock, all logic on rising edge
//   reset         in   1         synchronous, active-high; clears all state
//   botoes        in   N_BOTOES  raw asynchronous buttons, active-high
//   zeraR         in   1         clear stored play
//   registraR     in   1         enable capture of play on jogada_feita
//   zeraI         in   1         clear answer timer and timeout
//   contaI        in   1         answer timer count enable
//   jogada_feita  out  1         one-cycle pulse: new press accepted
//   jogada        out  W_JOGADA  stored answer index (0..N_BOTOES-1)
//   jogada_valida out  1         stored index holds a captured play
//   timeout       out  1         sticky: answer time expired
//   db_botoes     out  N_BOTOES  debounced button vector (debug)
// BEHAVIOUR
//   Reset
//     - Synchronous, every cycle with reset=1.
//     - All outputs return to 0 and the FSM goes to OCIOSO.
//     - Synchroniser, debounce counters and timer are cleared.
//     - Reset mid-press: the button must be released, then pressed again, to produce a pulse.
//   Synchroniser
//     - Two flops per bit. No logic reads raw botoes.
//   Debounce, per bit
//     - A counter runs while the synchronised bit differs from db_botoes[i].
//     - The counter is cleared whenever the two match.
//     - db_botoes[i] takes the new level on the edge where the bit has differed for DEBOUNCE_CICLOS consecutive cycles.
//     - Glitches shorter than DEBOUNCE_CICLOS have no effect.
//   FSM states: OCIOSO, PULSO, ESPERA_SOLTA
//     - OCIOSO -> PULSO when db_botoes != 0.
//     - PULSO -> ESPERA_SOLTA unconditionally. jogada_feita=1 only in PULSO.
//     - ESPERA_SOLTA -> OCIOSO when db_botoes == 0.
//     - Extra buttons pressed while another is held are ignored until all buttons are released.
//   Latency
//     - jogada_feita is high exactly DEBOUNCE_CICLOS+3 edges after a clean raw rising edge.
//   Encoding
//     - The index is latched on entering PULSO from the db_botoes value at that time.
//     - Simultaneous presses: the lowest set index wins.
//   Play register, priority zeraR > capture > hold
//     - zeraR=1: jogada <= 0 and jogada_valida <= 0.
//     - Capture, when jogada_feita=1 and registraR=1: jogada <= index and jogada_valida <= 1.
//     - A pulse arriving while registraR=0 is discarded; the register keeps its value.
//   Timer, priority zeraI > contaI
//     - zeraI=1: count <= 0 and timeout <= 0.
//     - Otherwise, with contaI=1, the count increments.
//     - When count reaches TIMEOUT_CICLOS, timeout <= 1 and the count saturates (no wrap).
//     - timeout stays high until zeraI or reset.
//     - A press does not stop the timer; the control unit handles that.
// TESTING (bench parameters: DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=10, N_BOTOES=4)
//   1. botoes=0100 held 20 cycles with registraR=1
//      -> exactly one jogada_feita pulse, 7 edges after the press;
//      -> jogada=2, jogada_valida=1, db_botoes=0100.
//   2. botoes=0001 pulsed for 3 cycles, then 0
//      -> no pulse; db_botoes stays 0000; jogada unchanged.
//   3. botoes=1010 pressed simultaneously, with registraR=1
//      -> one pulse, jogada=1.
//      -> Then 1000 held and 0010 released and re-pressed without full release -> no further pulse.
//   4. Press with registraR=0 -> pulse is seen but jogada_valida stays 0.
//      -> Next, zeraR and registraR both =1 in the pulse cycle -> jogada=0, jogada_valida=0.
//   5. zeraI=1 for 1 cycle, then contaI=1
//      -> timeout rises on the 10th counting edge and stays high for 20+ more cycles.
//      -> zeraI=1 for 1 cycle -> timeout=0 on the next edge.
//   6. reset=1 for 1 cycle while botoes=0001 is held and in ESPERA_SOLTA
//      -> all outputs are 0 after that edge, and no pulse occurs until release followed by a new press.

Source files
------------

// File: rtl/captura_jogada.sv
// -----------------------------------------------------------------------------
// captura_jogada
//   Player-input front end for the game control unit. Synchronises and
//   debounces the answer buttons, emits a one-cycle jogada_feita pulse per
//   accepted press, stores the encoded answer index and runs the answer timer.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high; clears all state
//   botoes         in   raw asynchronous buttons, active-high
//   zeraR          in   clear stored play (highest priority)
//   registraR      in   allow capture of the index on jogada_feita
//   zeraI          in   clear answer timer and timeout (highest priority)
//   contaI         in   answer timer count enable
//   jogada_feita   out  one-cycle pulse: new press accepted
//   jogada         out  stored answer index
//   jogada_valida  out  stored index holds a captured play
//   timeout        out  sticky: answer time expired
//   db_botoes      out  debounced button vector
// -----------------------------------------------------------------------------
module captura_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int W_JOGADA        = 2,
    parameter int DEBOUNCE_CICLOS = 1000,
    parameter int TIMEOUT_CICLOS  = 5000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                zeraR,
    input  logic                registraR,
    input  logic                zeraI,
    input  logic                contaI,
    output logic                jogada_feita,
    output logic [W_JOGADA-1:0] jogada,
    output logic                jogada_valida,
    output logic                timeout,
    output logic [N_BOTOES-1:0] db_botoes
);

    localparam int DB_W = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int TM_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [DB_W-1:0] DB_LIM = DB_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [TM_W-1:0] TM_LIM = TM_W'(TIMEOUT_CICLOS);

    typedef enum logic [1:0] {
        OCIOSO       = 2'b00,
        PULSO        = 2'b01,
        ESPERA_SOLTA = 2'b10
    } estado_t;

    // Lowest set index wins when several buttons are pressed together.
    function automatic logic [W_JOGADA-1:0] codifica(input logic [N_BOTOES-1:0] v);
        logic [W_JOGADA-1:0] r;
        r = '0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = W_JOGADA'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [N_BOTOES-1:0] sync1_q;
    logic [N_BOTOES-1:0] sync2_q;
    logic [N_BOTOES-1:0] db_q;
    logic [DB_W-1:0]     db_cnt_q [N_BOTOES];
    logic [1:0]          prim_q;
    logic                bloq_q;
    estado_t             estado_q;
    estado_t             estado_d;
    logic [W_JOGADA-1:0] idx_q;
    logic [W_JOGADA-1:0] idx_d;
    logic                pulso_q;
    logic [W_JOGADA-1:0] jogada_q;
    logic                valida_q;
    logic [TM_W-1:0]     tmr_q;
    logic                timeout_q;

    // Two-flop synchroniser for the raw buttons.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= botoes;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: level is accepted after DEBOUNCE_CICLOS consecutive differing cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < N_BOTOES; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BOTOES; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LIM) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // Post-reset lockout. Reset clears the synchroniser, so a button held
    // through reset would otherwise look like a fresh press. The lock is only
    // released once the synchroniser carries real samples again (prim_q == 2)
    // and both the synchronised and debounced vectors show all buttons up.
    always_ff @(posedge clock) begin
        if (reset) begin
            prim_q <= 2'd0;
            bloq_q <= 1'b1;
        end else begin
            if (prim_q != 2'd2) begin
                prim_q <= prim_q + 2'd1;
            end else begin
                prim_q <= prim_q;
            end
            if (bloq_q && (prim_q == 2'd2) && (sync2_q == '0) && (db_q == '0)) begin
                bloq_q <= 1'b0;
            end else begin
                bloq_q <= bloq_q;
            end
        end
    end

    // Press FSM next-state logic; index is latched on entry to PULSO.
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        case (estado_q)
            OCIOSO: begin
                if ((db_q != '0) && !bloq_q) begin
                    estado_d = PULSO;
                    idx_d    = codifica(db_q);
                end else begin
                    estado_d = OCIOSO;
                end
            end
            PULSO: begin
                estado_d = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                if (db_q == '0) begin
                    estado_d = OCIOSO;
                end else begin
                    estado_d = ESPERA_SOLTA;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Press FSM state, latched index and registered pulse output.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
            idx_q    <= '0;
            pulso_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            pulso_q  <= (estado_d == PULSO);
        end
    end

    // Play register: zeraR beats capture, capture beats hold.
    always_ff @(posedge clock) begin
        if (reset || zeraR) begin
            jogada_q <= '0;
            valida_q <= 1'b0;
        end else if (pulso_q && registraR) begin
            jogada_q <= idx_q;
            valida_q <= 1'b1;
        end else begin
            jogada_q <= jogada_q;
            valida_q <= valida_q;
        end
    end

    // Answer timer: saturates at TIMEOUT_CICLOS, timeout is sticky until zeraI.
    always_ff @(posedge clock) begin
        if (reset || zeraI) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else if (contaI) begin
            if (tmr_q != TM_LIM) begin
                tmr_q <= tmr_q + TM_W'(1);
            end else begin
                tmr_q <= tmr_q;
            end
            // The edge that takes the count to TIMEOUT_CICLOS also raises timeout.
            if (tmr_q >= (TM_LIM - TM_W'(1))) begin
                timeout_q <= 1'b1;
            end else begin
                timeout_q <= timeout_q;
            end
        end else begin
            tmr_q     <= tmr_q;
            timeout_q <= timeout_q;
        end
    end

    assign jogada_feita  = pulso_q;
    assign jogada        = jogada_q;
    assign jogada_valida = valida_q;
    assign timeout       = timeout_q;
    assign db_botoes     = db_q;

endmodule

// File: tb/tb_captura_jogada.sv
// -----------------------------------------------------------------------------
// tb_captura_jogada
//   Directed bench for captura_jogada with DEBOUNCE_CICLOS=4, TIMEOUT_CICLOS=10.
//   Each press pushes the cycle at which its pulse must appear; a negedge
//   monitor pops and compares whenever jogada_feita is high.
// -----------------------------------------------------------------------------
module tb_captura_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes;
    logic       zeraR;
    logic       registraR;
    logic       zeraI;
    logic       contaI;
    logic       jogada_feita;
    logic [1:0] jogada;
    logic       jogada_valida;
    logic       timeout;
    logic [3:0] db_botoes;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;
    int exp_q[$];

    captura_jogada #(
        .N_BOTOES       (4),
        .W_JOGADA       (2),
        .DEBOUNCE_CICLOS(4),
        .TIMEOUT_CICLOS (10)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes       (botoes),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .zeraI        (zeraI),
        .contaI       (contaI),
        .jogada_feita (jogada_feita),
        .jogada       (jogada),
        .jogada_valida(jogada_valida),
        .timeout      (timeout),
        .db_botoes    (db_botoes)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nome, got, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Press: raw edge now, pulse expected 7 edges later.
    task automatic press(input logic [3:0] v);
        botoes = v;
        exp_q.push_back(cyc + 7);
    endtask

    // Monitor: every pulse cycle must match the next expected cycle.
    always @(negedge clock) begin
        if (jogada_feita === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse got=pulse expected=none (cycle %0d)", cyc);
            end else begin
                check("pulse_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    initial begin
        int low;
        reset = 1'b1; botoes = 4'b0000; zeraR = 1'b0; registraR = 1'b0;
        zeraI = 1'b0; contaI = 1'b0;
        tick(2);
        check("rst_feita", jogada_feita, 0);
        check("rst_jogada", jogada, 0);
        check("rst_valida", jogada_valida, 0);
        check("rst_timeout", timeout, 0);
        check("rst_db", db_botoes, 0);
        reset = 1'b0;
        tick(5);

        // 1: clean press of button 2
        registraR = 1'b1;
        press(4'b0100);
        tick(20);
        check("t1_jogada", jogada, 2);
        check("t1_valida", jogada_valida, 1);
        check("t1_db", db_botoes, 4'b0100);
        check("t1_pulses", pulses, 1);
        botoes = 4'b0000;
        tick(10);

        // 2: 3-cycle glitch is rejected
        botoes = 4'b0001;
        tick(3);
        botoes = 4'b0000;
        tick(10);
        check("t2_db", db_botoes, 0);
        check("t2_jogada", jogada, 2);
        check("t2_pulses", pulses, 1);

        // 3: simultaneous press, lowest wins; partial release ignored
        press(4'b1010);
        tick(12);
        check("t3_jogada", jogada, 1);
        check("t3_pulses", pulses, 2);
        botoes = 4'b1000;
        tick(10);
        check("t3_db_partial", db_botoes, 4'b1000);
        botoes = 4'b1010;
        tick(10);
        check("t3_db_repress", db_botoes, 4'b1010);
        check("t3_no_extra", pulses, 2);
        botoes = 4'b0000;
        tick(10);

        // 4: registraR=0 discards, then zeraR beats capture
        zeraR = 1'b1;
        tick(1);
        zeraR = 1'b0;
        check("t4_clr_valida", jogada_valida, 0);
        check("t4_clr_jogada", jogada, 0);
        registraR = 1'b0;
        press(4'b1000);
        tick(12);
        check("t4_pulses", pulses, 3);
        check("t4_discard_valida", jogada_valida, 0);
        check("t4_discard_jogada", jogada, 0);
        botoes = 4'b0000;
        tick(10);
        registraR = 1'b1;
        press(4'b1000);
        tick(12);
        check("t4_cap_jogada", jogada, 3);
        check("t4_cap_valida", jogada_valida, 1);
        botoes = 4'b0000;
        tick(10);
        press(4'b0100);
        tick(7);
        zeraR = 1'b1;
        tick(1);
        zeraR = 1'b0;
        check("t4_prio_jogada", jogada, 0);
        check("t4_prio_valida", jogada_valida, 0);
        check("t4_prio_pulses", pulses, 5);
        tick(5);
        botoes = 4'b0000;
        tick(10);

        // 5: timer
        check("t5_idle_timeout", timeout, 0);
        zeraI = 1'b1;
        tick(1);
        zeraI = 1'b0;
        contaI = 1'b1;
        tick(9);
        check("t5_before", timeout, 0);
        tick(1);
        check("t5_rise", timeout, 1);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (timeout !== 1'b1) low++;
        end
        check("t5_sticky_drops", low, 0);
        zeraI = 1'b1;
        contaI = 1'b0;
        tick(1);
        zeraI = 1'b0;
        check("t5_clear", timeout, 0);

        // 6: reset while held in ESPERA_SOLTA
        contaI = 1'b1;
        press(4'b0001);
        tick(12);
        check("t6_pre_valida", jogada_valida, 1);
        check("t6_pre_timeout", timeout, 1);
        contaI = 1'b0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_rst_feita", jogada_feita, 0);
        check("t6_rst_jogada", jogada, 0);
        check("t6_rst_valida", jogada_valida, 0);
        check("t6_rst_timeout", timeout, 0);
        check("t6_rst_db", db_botoes, 0);
        tick(20);
        check("t6_held_no_pulse", pulses, 6);
        botoes = 4'b0000;
        tick(10);
        press(4'b0010);
        tick(12);
        check("t6_new_pulses", pulses, 7);
        check("t6_new_jogada", jogada, 1);
        check("t6_new_valida", jogada_valida, 1);
        botoes = 4'b0000;
        tick(5);

        check("pending_pulses", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
